// File: rtl/pe2_core_if.sv
// Shared coefficient types and modular helpers for the ML-KEM polynomial unit,
// plus the sample-in / result-out interface of the pe2_core butterfly.
package poly_arith_pkg;

   localparam int unsigned WIDTH = 12;
   localparam int unsigned Q     = 3329;

   typedef logic [WIDTH-1:0] coeff_t;

   typedef enum logic [2:0] {
      PE_NTT    = 3'd0,
      PE_INTT   = 3'd1,
      PE_CWM    = 3'd2,
      PE_ADDSUB = 3'd3,
      PE_COMP   = 3'd4,
      PE_DECOMP = 3'd5
   } pe_mode_e;

   localparam logic [12:0] Q13       = 13'(Q);
   localparam logic [36:0] BARRETT_M = 37'd5039;  // floor(2^24 / Q)

   function automatic coeff_t mod_add(input coeff_t a, input coeff_t b);
      logic [12:0] s;
      s = {1'b0, a} + {1'b0, b};
      return (s >= Q13) ? coeff_t'(s - Q13) : coeff_t'(s);
   endfunction

   function automatic coeff_t mod_sub(input coeff_t a, input coeff_t b);
      logic [12:0] d;
      d = {1'b0, a} - {1'b0, b};
      return (a < b) ? coeff_t'(d + Q13) : coeff_t'(d);
   endfunction

   // The quotient estimate is at most one short, so the remainder is below 2Q
   // and fits in 13 bits; one conditional subtract makes it canonical.
   function automatic coeff_t barrett_reduce(input logic [23:0] x);
      logic [36:0] t;
      logic [12:0] qh;
      logic [12:0] r;
      t  = {13'b0, x} * BARRETT_M;
      qh = 13'(t >> 24);
      r  = x[12:0] - 13'(qh * Q13);
      return (r >= Q13) ? coeff_t'(r - Q13) : coeff_t'(r);
   endfunction

endpackage

interface pe2_core_if;
   import poly_arith_pkg::*;

   coeff_t   a2_i;
   coeff_t   b2_i;
   coeff_t   w1_i;
   coeff_t   w2_i;
   pe_mode_e ctrl_i;
   logic     valid_i;
   coeff_t   u2_o;
   coeff_t   v2_o;
   coeff_t   m_o;
   logic     valid_o;
   logic     valid_m_o;

   modport master (
      output a2_i, b2_i, w1_i, w2_i, ctrl_i, valid_i,
      input  u2_o, v2_o, m_o, valid_o, valid_m_o
   );

   modport slave (
      input  a2_i, b2_i, w1_i, w2_i, ctrl_i, valid_i,
      output u2_o, v2_o, m_o, valid_o, valid_m_o
   );

endinterface

// File: rtl/pe2_core.sv
// Mixed-radix modular butterfly (q = 3329): pre-add/sub, two Barrett multipliers,
// post-add/sub. Fixed 4-cycle U/V latency, Karatsuba cross term M one cycle later.
module pe2_core
   import poly_arith_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   pe2_core_if.slave pe
);

   localparam coeff_t ONE = coeff_t'(1);

   // Stage 1: pre-add/sub result and selected multiplier operands
   logic        valid1_q, valid1_d;
   pe_mode_e    mode1_q, mode1_d;
   coeff_t      x1_q, x1_d, y1_q, y1_d;
   coeff_t      x2_q, x2_d, y2_q, y2_d;
   // Stage 2: exact 24-bit products
   logic        valid2_q, valid2_d;
   pe_mode_e    mode2_q, mode2_d;
   logic [23:0] prod1_q, prod1_d, prod2_q, prod2_d;
   // Stage 3: canonical products
   logic        valid3_q, valid3_d;
   pe_mode_e    mode3_q, mode3_d;
   coeff_t      r1_q, r1_d, r2_q, r2_d;
   // Stage 4: U/V outputs; stage 5: cross term
   logic        valid_o_q, valid_o_d;
   logic        cwm4_q, cwm4_d;
   coeff_t      u_q, u_d, v_q, v_d;
   logic        valid_m_q, valid_m_d;
   coeff_t      m_q, m_d;

   coeff_t      pre_sum;
   coeff_t      pre_dif;

   always_comb begin
      // NOTE: every value driven here gets a default first, so no path can infer a latch.
      pre_sum  = mod_add(pe.a2_i, pe.b2_i);
      pre_dif  = mod_sub(pe.a2_i, pe.b2_i);
      valid1_d = pe.valid_i;
      mode1_d  = pe.ctrl_i;
      x1_d     = '0;
      y1_d     = '0;
      x2_d     = '0;
      y2_d     = '0;
      unique case (pe.ctrl_i)
         PE_NTT, PE_CWM, PE_COMP, PE_DECOMP: begin
            x1_d = pe.a2_i;
            y1_d = pe.w1_i;
            x2_d = pe.b2_i;
            y2_d = pe.w2_i;
         end
         PE_INTT: begin
            x1_d = pre_sum;
            y1_d = pe.w1_i;
            x2_d = pre_dif;
            y2_d = pe.w2_i;
         end
         // Multiplying by one carries ADDSUB through the same pipeline depth.
         PE_ADDSUB: begin
            x1_d = pre_sum;
            y1_d = ONE;
            x2_d = pre_dif;
            y2_d = ONE;
         end
         default: ;
      endcase

      valid2_d = valid1_q;
      mode2_d  = mode1_q;
      prod1_d  = 24'(x1_q) * 24'(y1_q);
      prod2_d  = 24'(x2_q) * 24'(y2_q);

      valid3_d = valid2_q;
      mode3_d  = mode2_q;
      r1_d     = barrett_reduce(prod1_q);
      r2_d     = barrett_reduce(prod2_q);

      valid_o_d = valid3_q;
      cwm4_d    = valid3_q && (mode3_q == PE_CWM);
      u_d       = '0;
      v_d       = '0;
      unique case (mode3_q)
         PE_NTT: begin
            u_d = mod_add(r1_q, r2_q);
            v_d = mod_sub(r1_q, r2_q);
         end
         PE_INTT, PE_CWM, PE_ADDSUB, PE_COMP, PE_DECOMP: begin
            u_d = r1_q;
            v_d = r2_q;
         end
         default: ;
      endcase

      valid_m_d = cwm4_q;
      m_d       = mod_add(u_q, v_q);
   end

   // NOTE: datapath registers are reset as well, so every output reads 0 during reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid1_q  <= 1'b0;
         mode1_q   <= PE_NTT;
         x1_q      <= '0;
         y1_q      <= '0;
         x2_q      <= '0;
         y2_q      <= '0;
         valid2_q  <= 1'b0;
         mode2_q   <= PE_NTT;
         prod1_q   <= '0;
         prod2_q   <= '0;
         valid3_q  <= 1'b0;
         mode3_q   <= PE_NTT;
         r1_q      <= '0;
         r2_q      <= '0;
         valid_o_q <= 1'b0;
         cwm4_q    <= 1'b0;
         u_q       <= '0;
         v_q       <= '0;
         valid_m_q <= 1'b0;
         m_q       <= '0;
      end else begin
         // NOTE: non-blocking assignments so every stage samples the previous stage's old value.
         valid1_q  <= valid1_d;
         mode1_q   <= mode1_d;
         x1_q      <= x1_d;
         y1_q      <= y1_d;
         x2_q      <= x2_d;
         y2_q      <= y2_d;
         valid2_q  <= valid2_d;
         mode2_q   <= mode2_d;
         prod1_q   <= prod1_d;
         prod2_q   <= prod2_d;
         valid3_q  <= valid3_d;
         mode3_q   <= mode3_d;
         r1_q      <= r1_d;
         r2_q      <= r2_d;
         valid_o_q <= valid_o_d;
         cwm4_q    <= cwm4_d;
         u_q       <= u_d;
         v_q       <= v_d;
         valid_m_q <= valid_m_d;
         m_q       <= m_d;
      end
   end

   assign pe.u2_o      = u_q;
   assign pe.v2_o      = v_q;
   assign pe.m_o       = m_q;
   assign pe.valid_o   = valid_o_q;
   assign pe.valid_m_o = valid_m_q;

endmodule

// File: tb/tb_pe2_core.sv
// Scoreboard bench for pe2_core: directed vectors, a mixed-mode random stream
// checked against an integer golden model, bubbles and a mid-stream reset.
module tb_pe2_core;
   import poly_arith_pkg::*;

   localparam int QI = 3329;

   typedef struct {
      int  u;
      int  v;
      int  m;
      bit  cwm;
      int  due;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   issued_uv = 0;
   int   issued_m = 0;
   int   n_valid = 0;
   int   n_valid_m = 0;

   exp_t uv_q[$];
   exp_t m_q[$];

   pe2_core_if pif();

   pe2_core dut (
      .clk (clk),
      .rst (rst),
      .pe  (pif)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic void model(input pe_mode_e md, input int a, input int b,
                                 input int w1, input int w2, output int u, output int v);
      int t1, t2;
      u = 0;
      v = 0;
      case (md)
         PE_NTT: begin
            t1 = (a * w1) % QI;
            t2 = (b * w2) % QI;
            u  = (t1 + t2) % QI;
            v  = (t1 - t2 + QI) % QI;
         end
         PE_INTT: begin
            u = (((a + b) % QI) * w1) % QI;
            v = (((a - b + QI) % QI) * w2) % QI;
         end
         PE_CWM, PE_COMP, PE_DECOMP: begin
            u = (a * w1) % QI;
            v = (b * w2) % QI;
         end
         PE_ADDSUB: begin
            u = (a + b) % QI;
            v = (a - b + QI) % QI;
         end
         default: ;
      endcase
   endfunction

   // Called just after a falling edge: present one sample for the next rising edge.
   task automatic drive(input pe_mode_e md, input int a, input int b, input int w1,
                        input int w2, input int eu, input int ev, input int em);
      exp_t e;
      pif.a2_i    = 12'(a);
      pif.b2_i    = 12'(b);
      pif.w1_i    = 12'(w1);
      pif.w2_i    = 12'(w2);
      pif.ctrl_i  = md;
      pif.valid_i = 1'b1;
      e.u   = eu;
      e.v   = ev;
      e.m   = em;
      e.cwm = (md == PE_CWM);
      e.due = cyc + 4;
      uv_q.push_back(e);
      issued_uv++;
      if (e.cwm) issued_m++;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      pif.valid_i = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && (uv_q.size() != 0 || m_q.size() != 0); i++) @(negedge clk);
      check("drain uv_q", uv_q.size(), 0);
      check("drain m_q", m_q.size(), 0);
   endtask

   // Output monitor: compares valids every cycle and data whenever a result is due.
   exp_t mon_e;
   bit   exp_v;
   always @(negedge clk) begin
      if (rst) begin
         exp_v = (uv_q.size() != 0) && (uv_q[0].due == cyc);
         check("valid_o", 32'(pif.valid_o), 32'(exp_v));
         if (pif.valid_o) n_valid++;
         if (uv_q.size() != 0 && uv_q[0].due <= cyc) begin
            mon_e = uv_q.pop_front();
            if (pif.valid_o && exp_v) begin
               check("u2_o", 32'(pif.u2_o), mon_e.u);
               check("v2_o", 32'(pif.v2_o), mon_e.v);
            end
            if (mon_e.cwm) begin
               mon_e.due = mon_e.due + 1;
               m_q.push_back(mon_e);
            end
         end

         exp_v = (m_q.size() != 0) && (m_q[0].due == cyc);
         check("valid_m_o", 32'(pif.valid_m_o), 32'(exp_v));
         if (pif.valid_m_o) n_valid_m++;
         if (m_q.size() != 0 && m_q[0].due <= cyc) begin
            mon_e = m_q.pop_front();
            if (pif.valid_m_o && exp_v) check("m_o", 32'(pif.m_o), mon_e.m);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "timeout");
   end

   initial begin
      pe_mode_e md;
      int a, b, w1, w2, eu, ev;

      pif.a2_i    = '0;
      pif.b2_i    = '0;
      pif.w1_i    = '0;
      pif.w2_i    = '0;
      pif.ctrl_i  = PE_NTT;
      pif.valid_i = 1'b0;

      #1 rst = 1'b0;
      #1;
      check("reset valid_o", 32'(pif.valid_o), 0);
      check("reset valid_m_o", 32'(pif.valid_m_o), 0);
      check("reset u2_o", 32'(pif.u2_o), 0);
      check("reset v2_o", 32'(pif.v2_o), 0);
      check("reset m_o", 32'(pif.m_o), 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // Directed vectors, back-to-back with mode changes, then bubbles.
      drive(PE_NTT,    10,   2,    999,  5,    13,   3322, 0);
      drive(PE_NTT,    3328, 3328, 0,    3328, 1,    3328, 0);
      drive(PE_INTT,   20,   10,   999,  2,    9,    20,   0);
      drive(PE_CWM,    100,  50,   4,    2,    400,  100,  500);
      drive(PE_ADDSUB, 1000, 2500, 7,    9,    171,  1829, 0);
      drive(PE_COMP,   1234, 500,  10,   5,    2353, 2500, 0);
      idle(2);
      drive(PE_CWM,    3328, 3328, 3328, 3328, 1,    1,    2);
      drive(PE_DECOMP, 3328, 1,    3328, 1,    1,    1,    0);
      drive(PE_INTT,   0,    1,    1,    3328, 1,    1,    0);
      drive(pe_mode_e'(3'd7), 5, 6, 7,   8,    0,    0,    0);
      drive(PE_ADDSUB, 0,    0,    0,    0,    0,    0,    0);
      idle(1);
      drive(PE_CWM,    3000, 2000, 1,    1,    3000, 2000, 1671);
      idle(3);
      drain();

      // Random back-to-back stream with mixed modes, including an unused code.
      for (int i = 0; i < 100; i++) begin
         md = pe_mode_e'(3'($urandom_range(0, 6)));
         a  = int'($urandom_range(0, QI - 1));
         b  = int'($urandom_range(0, QI - 1));
         w1 = int'($urandom_range(0, QI - 1));
         w2 = int'($urandom_range(0, QI - 1));
         model(md, a, b, w1, w2, eu, ev);
         drive(md, a, b, w1, w2, eu, ev, (eu + ev) % QI);
      end
      idle(1);
      drain();
      check("valid_o count", n_valid, issued_uv);
      check("valid_m_o count", n_valid_m, issued_m);

      // Reset while CWM samples are in flight and emerging.
      for (int i = 0; i < 6; i++) drive(PE_CWM, 11 + i, 7, 3, 5, 33 + 3 * i, 35, (68 + 3 * i) % QI);
      pif.valid_i = 1'b0;
      #1;
      check("pre-reset valid_o", 32'(pif.valid_o), 1);
      #1 rst = 1'b0;
      #1;
      check("mid reset valid_o", 32'(pif.valid_o), 0);
      check("mid reset valid_m_o", 32'(pif.valid_m_o), 0);
      check("mid reset u2_o", 32'(pif.u2_o), 0);
      check("mid reset m_o", 32'(pif.m_o), 0);
      uv_q.delete();
      m_q.delete();
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
      idle(5);

      // First sample after reset keeps the fixed latency.
      drive(PE_CWM, 100, 50, 4, 2, 400, 100, 500);
      idle(1);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
